mmio_requester: RTL and testbench

MMIO initiator that drives the host side of the AFU's memory-mapped register interface. It accepts single-beat read and write commands on a valid/ready port and presents them as one-cycle MMIO write or read requests with address, transaction ID (TID) and data. For reads, it waits for the TID-matched read response and returns the data, or flags a timeout. It is the bench/loopback counterpart of the AFU MMIO responder and lets on-chip logic or a test harness exercise AFU registers such as 0x0020 without a host.

---
 rtl/mmio_requester.sv | 158 +++++++++++++++
 tb/tb_mmio_requester.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_requester.sv
// MMIO initiator: turns single-beat read/write commands into one-cycle MMIO requests and collects TID-matched read data.
// Latency: write strobe 1 cycle after accept; read completion 2+R cycles after accept, or a timeout TIMEOUT_CYCLES after the request.
// Backpressure: one command in flight; cmd_ready is low from acceptance until the write is issued or the read completes/times out.
module mmio_requester #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 64,
   parameter int TID_W          = 9,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              mmio_wr_valid,
   output logic              mmio_rd_valid,
   output logic [ADDR_W-1:0] mmio_addr,
   output logic [TID_W-1:0]  mmio_tid,
   output logic [DATA_W-1:0] mmio_wdata,
   input  logic              rsp_valid,
   input  logic [TID_W-1:0]  rsp_tid,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_timeout,
   output logic [7:0]        err_cnt
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e            state_q;
   logic              write_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              cmd_ready_q;
   logic              mmio_wr_valid_q;
   logic              mmio_rd_valid_q;
   logic [ADDR_W-1:0] mmio_addr_q;
   logic [TID_W-1:0]  mmio_tid_q;
   logic [DATA_W-1:0] mmio_wdata_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_timeout_q;
   logic [7:0]        err_cnt_q;
   logic [7:0]        err_cnt_d;
   logic              rsp_match;
   logic              err_inc;

   // Response classification and saturating error-count next state
   always_comb begin
      rsp_match = rsp_valid && (rsp_tid == mmio_tid_q);
      err_inc   = rsp_valid && ((state_q != WAIT) || !rsp_match);
      err_cnt_d = err_cnt_q;
      if (err_inc && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Control FSM with all outputs registered; reset drops any outstanding read silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         write_q         <= 1'b0;
         cnt_q           <= '0;
         cmd_ready_q     <= 1'b0;
         mmio_wr_valid_q <= 1'b0;
         mmio_rd_valid_q <= 1'b0;
         mmio_addr_q     <= '0;
         mmio_tid_q      <= '0;
         mmio_wdata_q    <= '0;
         rd_valid_q      <= 1'b0;
         rd_data_q       <= '0;
         rd_timeout_q    <= 1'b0;
         err_cnt_q       <= 8'd0;
      end else begin
         // strobes are single-cycle pulses unless re-raised below
         mmio_wr_valid_q <= 1'b0;
         mmio_rd_valid_q <= 1'b0;
         rd_valid_q      <= 1'b0;
         err_cnt_q       <= err_cnt_d;

         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  mmio_addr_q <= cmd_addr;
                  write_q     <= cmd_write;
                  if (cmd_write) begin
                     mmio_wdata_q    <= cmd_data;
                     mmio_wr_valid_q <= 1'b1;
                  end else begin
                     mmio_rd_valid_q <= 1'b1;
                  end
                  cmd_ready_q <= 1'b0;
                  state_q     <= REQ;
               end else begin
                  // also raises ready on the first edge after reset
                  cmd_ready_q <= 1'b1;
               end
            end

            REQ: begin
               if (write_q) begin
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  cnt_q   <= '0;
                  state_q <= WAIT;
               end
            end

            WAIT: begin
               if (rsp_match) begin
                  // a match on the final timeout cycle still completes normally
                  rd_data_q    <= rsp_data;
                  rd_valid_q   <= 1'b1;
                  rd_timeout_q <= 1'b0;
                  mmio_tid_q   <= mmio_tid_q + 1'b1;
                  cmd_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  rd_data_q    <= '0;
                  rd_valid_q   <= 1'b1;
                  rd_timeout_q <= 1'b1;
                  mmio_tid_q   <= mmio_tid_q + 1'b1;
                  cmd_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign mmio_wr_valid = mmio_wr_valid_q;
   assign mmio_rd_valid = mmio_rd_valid_q;
   assign mmio_addr     = mmio_addr_q;
   assign mmio_tid      = mmio_tid_q;
   assign mmio_wdata    = mmio_wdata_q;
   assign rd_valid      = rd_valid_q;
   assign rd_data       = rd_data_q;
   assign rd_timeout    = rd_timeout_q;
   assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_mmio_requester.sv
// Directed bench for mmio_requester: instance A (TID_W=9, timeout 8) and instance B (TID_W=2, timeout 8).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Responses are supplied directly by the bench at hand-chosen cycles.
module tb_mmio_requester;

   logic        clk;
   logic        rst_n_a, rst_n_b;
   logic        cmd_valid_a, cmd_valid_b;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [63:0] cmd_data;
   logic        rsp_valid_a, rsp_valid_b;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;

   logic        cmd_ready_a, mwr_a, mrd_a, rdv_a, rdto_a;
   logic [15:0] maddr_a;
   logic [8:0]  mtid_a;
   logic [63:0] mwdata_a, rdd_a;
   logic [7:0]  err_a;

   logic        cmd_ready_b, mwr_b, mrd_b, rdv_b, rdto_b;
   logic [15:0] maddr_b;
   logic [1:0]  mtid_b;
   logic [63:0] mwdata_b, rdd_b;
   logic [7:0]  err_b;

   int n_asrt = 0;
   int n_fail = 0;

   mmio_requester #(.ADDR_W(16), .DATA_W(64), .TID_W(9), .TIMEOUT_CYCLES(8)) dut_a (
      .clk(clk), .rst_n(rst_n_a),
      .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .mmio_wr_valid(mwr_a), .mmio_rd_valid(mrd_a), .mmio_addr(maddr_a),
      .mmio_tid(mtid_a), .mmio_wdata(mwdata_a),
      .rsp_valid(rsp_valid_a), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
      .rd_valid(rdv_a), .rd_data(rdd_a), .rd_timeout(rdto_a), .err_cnt(err_a)
   );

   mmio_requester #(.ADDR_W(16), .DATA_W(64), .TID_W(2), .TIMEOUT_CYCLES(8)) dut_b (
      .clk(clk), .rst_n(rst_n_b),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .mmio_wr_valid(mwr_b), .mmio_rd_valid(mrd_b), .mmio_addr(maddr_b),
      .mmio_tid(mtid_b), .mmio_wdata(mwdata_b),
      .rsp_valid(rsp_valid_b), .rsp_tid(rsp_tid[1:0]), .rsp_data(rsp_data),
      .rd_valid(rdv_b), .rd_data(rdd_b), .rd_timeout(rdto_b), .err_cnt(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
      cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
      rsp_valid_a = 1'b0; rsp_valid_b = 1'b0; rsp_tid = '0; rsp_data = '0;

      // ---- reset for 3 cycles
      repeat (3) tick();
      chk("rst_cmd_ready", 64'(cmd_ready_a), 64'd0);
      chk("rst_wr_valid", 64'(mwr_a), 64'd0);
      chk("rst_rd_valid_req", 64'(mrd_a), 64'd0);
      chk("rst_tid", 64'(mtid_a), 64'd0);
      chk("rst_err", 64'(err_a), 64'd0);
      chk("rst_rd_valid", 64'(rdv_a), 64'd0);
      chk("rst_b_cmd_ready", 64'(cmd_ready_b), 64'd0);
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      #1;
      chk("ready_before_edge", 64'(cmd_ready_a), 64'd0);
      tick();
      chk("ready_after_edge", 64'(cmd_ready_a), 64'd1);
      chk("ready_after_edge_b", 64'(cmd_ready_b), 64'd1);

      // ---- write 0x0020
      cmd_valid_a = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0020;
      cmd_data = 64'hDEADBEEF_01234567;
      tick();
      cmd_valid_a = 1'b0;
      chk("wr_strobe", 64'(mwr_a), 64'd1);
      chk("wr_no_rd_strobe", 64'(mrd_a), 64'd0);
      chk("wr_addr", 64'(maddr_a), 64'h0020);
      chk("wr_data", mwdata_a, 64'hDEADBEEF_01234567);
      chk("wr_tid", 64'(mtid_a), 64'd0);
      chk("wr_ready_low", 64'(cmd_ready_a), 64'd0);
      tick();
      chk("wr_strobe_clear", 64'(mwr_a), 64'd0);
      chk("wr_ready_back", 64'(cmd_ready_a), 64'd1);

      // ---- read 0x0020, response 3 cycles after acceptance
      cmd_valid_a = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020;
      tick();
      cmd_valid_a = 1'b0;
      chk("rd0_strobe", 64'(mrd_a), 64'd1);
      chk("rd0_tid", 64'(mtid_a), 64'd0);
      chk("rd0_no_wr", 64'(mwr_a), 64'd0);
      tick();
      chk("rd0_strobe_clear", 64'(mrd_a), 64'd0);
      tick();
      chk("rd0_not_done", 64'(rdv_a), 64'd0);
      rsp_valid_a = 1'b1; rsp_tid = 9'd0; rsp_data = 64'hDEADBEEF_01234567;
      tick();
      rsp_valid_a = 1'b0;
      chk("rd0_valid", 64'(rdv_a), 64'd1);
      chk("rd0_timeout", 64'(rdto_a), 64'd0);
      chk("rd0_data", rdd_a, 64'hDEADBEEF_01234567);
      chk("rd0_ready", 64'(cmd_ready_a), 64'd1);
      chk("rd0_tid_adv", 64'(mtid_a), 64'd1);
      tick();
      chk("rd0_valid_pulse", 64'(rdv_a), 64'd0);

      // ---- read with TID 1: mismatched TID 5 first, then the right one
      cmd_valid_a = 1'b1; cmd_addr = 16'h0028;
      tick();
      cmd_valid_a = 1'b0;
      chk("rd1_tid", 64'(mtid_a), 64'd1);
      chk("rd1_addr", 64'(maddr_a), 64'h0028);
      tick();
      rsp_valid_a = 1'b1; rsp_tid = 9'd5; rsp_data = 64'h5555;
      tick();
      chk("mis_err", 64'(err_a), 64'd1);
      chk("mis_no_done", 64'(rdv_a), 64'd0);
      rsp_tid = 9'd1; rsp_data = 64'hCAFEF00D_00000011;
      tick();
      rsp_valid_a = 1'b0;
      chk("mis_done", 64'(rdv_a), 64'd1);
      chk("mis_data", rdd_a, 64'hCAFEF00D_00000011);
      chk("mis_err_hold", 64'(err_a), 64'd1);
      tick();

      // ---- stray response in IDLE counts as an error even with the current TID
      rsp_valid_a = 1'b1; rsp_tid = 9'd2;
      tick();
      rsp_valid_a = 1'b0;
      chk("stray_err", 64'(err_a), 64'd2);
      chk("stray_no_done", 64'(rdv_a), 64'd0);
      tick();
      chk("stray_err_hold", 64'(err_a), 64'd2);

      // ---- timeout: no response, completion 8 cycles after the request cycle
      cmd_valid_a = 1'b1; cmd_addr = 16'h0030;
      tick();
      cmd_valid_a = 1'b0;
      tick();
      repeat (7) tick();
      chk("to_not_yet", 64'(rdv_a), 64'd0);
      tick();
      chk("to_valid", 64'(rdv_a), 64'd1);
      chk("to_flag", 64'(rdto_a), 64'd1);
      chk("to_data", rdd_a, 64'd0);
      chk("to_tid_adv", 64'(mtid_a), 64'd3);
      chk("to_ready", 64'(cmd_ready_a), 64'd1);
      tick();

      // ---- matching response on the final timeout cycle wins
      cmd_valid_a = 1'b1; cmd_addr = 16'h0038;
      tick();
      cmd_valid_a = 1'b0;
      tick();
      repeat (7) tick();
      chk("race_not_yet", 64'(rdv_a), 64'd0);
      rsp_valid_a = 1'b1; rsp_tid = 9'd3; rsp_data = 64'h0123_4567_89AB_CDEF;
      tick();
      rsp_valid_a = 1'b0;
      chk("race_valid", 64'(rdv_a), 64'd1);
      chk("race_flag", 64'(rdto_a), 64'd0);
      chk("race_data", rdd_a, 64'h0123_4567_89AB_CDEF);
      chk("race_err", 64'(err_a), 64'd2);
      tick();

      // ---- instance B: TID wrap over 5 reads
      for (int i = 0; i < 5; i++) begin
         cmd_valid_b = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020;
         tick();
         cmd_valid_b = 1'b0;
         chk($sformatf("wrap%0d_strobe", i), 64'(mrd_b), 64'd1);
         chk($sformatf("wrap%0d_tid", i), 64'(mtid_b), 64'(i % 4));
         tick();
         rsp_valid_b = 1'b1; rsp_tid = 9'(i % 4); rsp_data = 64'h100 + 64'(i);
         tick();
         rsp_valid_b = 1'b0;
         chk($sformatf("wrap%0d_valid", i), 64'(rdv_b), 64'd1);
         chk($sformatf("wrap%0d_data", i), rdd_b, 64'h100 + 64'(i));
         tick();
      end

      // ---- instance B: reset while waiting on a read
      cmd_valid_b = 1'b1; cmd_addr = 16'h0040;
      tick();
      cmd_valid_b = 1'b0;
      tick();
      tick();
      rst_n_b = 1'b0;
      #1;
      chk("mrst_ready", 64'(cmd_ready_b), 64'd0);
      chk("mrst_tid", 64'(mtid_b), 64'd0);
      chk("mrst_addr", 64'(maddr_b), 64'd0);
      chk("mrst_rdv", 64'(rdv_b), 64'd0);
      tick();
      tick();
      rst_n_b = 1'b1;
      #1;
      tick();
      chk("mrst_ready_back", 64'(cmd_ready_b), 64'd1);
      chk("mrst_no_rdv", 64'(rdv_b), 64'd0);
      chk("mrst_tid_zero", 64'(mtid_b), 64'd0);
      cmd_valid_b = 1'b1; cmd_addr = 16'h0048;
      tick();
      cmd_valid_b = 1'b0;
      chk("mrst_idle_accept", 64'(mrd_b), 64'd1);
      chk("mrst_idle_tid", 64'(mtid_b), 64'd0);
      tick();
      rsp_valid_b = 1'b1; rsp_tid = 9'd0; rsp_data = 64'hABCD;
      tick();
      rsp_valid_b = 1'b0;
      chk("mrst_done", 64'(rdv_b), 64'd1);
      chk("mrst_done_data", rdd_b, 64'hABCD);
      tick();

      // ---- instance B: err_cnt saturation via stray responses
      rsp_valid_b = 1'b1; rsp_tid = 9'd3;
      repeat (254) tick();
      chk("sat_254", 64'(err_b), 64'd254);
      repeat (6) tick();
      rsp_valid_b = 1'b0;
      chk("sat_255", 64'(err_b), 64'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
